// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: word reads over mem_rd/mem_ack, IR held for decode, PC advance/redirect.
// Optional read timeout fault is compiled in with `define FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pending_pc;
  logic [31:0] hold_next_pc;
  logic        timeout_hit;

  assign dbg_state    = state;
  assign hold_next_pc = redirect ? redirect_pc : pc + 32'd1;

`ifdef FETCH_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        fault_q;

  // Counts cycles a read has been outstanding; restarts at each new read and on entering DRAIN.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wait_cnt <= 16'd0;
    end else if (!mem_rd || (state == REQ && redirect && !mem_ack)) begin
      wait_cnt <= 16'd0;
    end else if (!mem_ack) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign timeout_hit = mem_rd && !mem_ack && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fault_q <= 1'b0;
    end else if (timeout_hit) begin
      fault_q <= 1'b1;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Decode handshake: ir_valid high means ir/pc hold an unconsumed instruction and stay
  // stable; the instruction is taken on any cycle with ir_valid & ir_ready (unless redirect).
  // Memory side: mem_rd/mem_addr are held until mem_ack; a read is never withdrawn.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= 32'd0;
      ir_valid   <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= 32'd0;
      pending_pc <= 32'd0;
    end else if (timeout_hit) begin
      mem_rd <= 1'b0;
      state  <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else if (run && !fetch_fault) begin
            state    <= REQ;
            mem_rd   <= 1'b1;
            mem_addr <= pc;
          end
        end
        REQ: begin
          if (!mem_rd) begin
            // Reissue cycle after a discarded read.
            mem_rd <= 1'b1;
            if (redirect) begin
              pc       <= redirect_pc;
              mem_addr <= redirect_pc;
            end else begin
              mem_addr <= pc;
            end
          end else if (redirect && mem_ack) begin
            pc     <= redirect_pc;
            mem_rd <= 1'b0;
          end else if (redirect) begin
            pending_pc <= redirect_pc;
            state      <= DRAIN;
          end else if (mem_ack) begin
            ir       <= mem_rdata;
            ir_valid <= 1'b1;
            mem_rd   <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (redirect || ir_ready) begin
            ir_valid <= 1'b0;
            pc       <= hold_next_pc;
            if (run) begin
              state    <= REQ;
              mem_rd   <= 1'b1;
              mem_addr <= hold_next_pc;
            end else begin
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            pc     <= redirect ? redirect_pc : pending_pc;
            mem_rd <= 1'b0;
            state  <= REQ;
          end else if (redirect) begin
            pending_pc <= redirect_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written reset/timeout sequences,
// then random traffic checked against an instruction-stream reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        fetch_fault;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .clr(clr), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc(pc), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .fetch_fault(fetch_fault), .dbg_state(dbg_state)
  );

  typedef struct {
    logic        run;
    logic        redirect;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_rd;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic        e_valid;
    logic        chk_ir;
  } vec_t;

  vec_t vecs[34];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic r, input logic rd, input logic [31:0] rp,
                               input logic a, input logic [31:0] d, input logic rdy,
                               input logic erd, input logic [31:0] ea, input logic [31:0] ep,
                               input logic [31:0] ei, input logic ev, input logic ci);
    vec_t v;
    v.run = r; v.redirect = rd; v.rpc = rp; v.ack = a; v.rdata = d; v.ready = rdy;
    v.e_rd = erd; v.e_addr = ea; v.e_pc = ep; v.e_ir = ei; v.e_valid = ev; v.chk_ir = ci;
    return v;
  endfunction

  // Instruction word the random-phase memory returns for each address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_idle();
    run = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0; ir_ready = 1'b0;
  endtask

  task automatic do_reset(input logic check_it);
    @(negedge clk);
    drive_idle();
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check_it) begin
      check1("rst_mem_rd", mem_rd, 1'b0);
      check32("rst_mem_addr", mem_addr, 32'h0);
      check32("rst_pc", pc, 32'h0);
      check32("rst_ir", ir, 32'h0);
      check1("rst_ir_valid", ir_valid, 1'b0);
      check1("rst_fault", fetch_fault, 1'b0);
    end
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_next;
    logic [31:0] prev_addr;
    logic        prev_rd;
    logic        acked_prev;
    int          wait_left;
    int          consumed;

    drive_idle();
    clr = 1'b0;

    // run, redir, rpc, ack, rdata, ready | rd, addr, pc, ir, valid, chk_ir
    vecs[0]  = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h0, 32'h0, 0, 0, 0);
    vecs[1]  = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h0, 32'h0, 0, 0, 0);
    vecs[2]  = mkv(1, 0, 0, 1, 32'h1234_5678, 1,          0, 0, 32'h0, 32'h1234_5678, 1, 1);
    vecs[3]  = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h1, 32'h1, 0, 0, 0);
    vecs[4]  = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h1, 32'h1, 0, 0, 0);
    vecs[5]  = mkv(1, 0, 0, 1, 32'hCAFE_0001, 0,          0, 0, 32'h1, 32'hCAFE_0001, 1, 1);
    for (int i = 6; i <= 10; i++)
      vecs[i] = mkv(1, 0, 0, 0, 0, 0,                     0, 0, 32'h1, 32'hCAFE_0001, 1, 1);
    vecs[11] = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h2, 32'h2, 0, 0, 0);
    vecs[12] = mkv(1, 0, 0, 1, 32'h77, 0,                 0, 0, 32'h2, 32'h77, 1, 1);
    vecs[13] = mkv(1, 1, 32'h40, 0, 0, 1,                 1, 32'h40, 32'h40, 0, 0, 0);
    vecs[14] = mkv(1, 0, 0, 1, 32'h4040, 0,               0, 0, 32'h40, 32'h4040, 1, 1);
    vecs[15] = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h41, 32'h41, 0, 0, 0);
    vecs[16] = mkv(1, 1, 32'h80, 0, 0, 1,                 1, 32'h41, 32'h41, 0, 0, 0);
    vecs[17] = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h41, 32'h41, 0, 0, 0);
    vecs[18] = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h41, 32'h41, 0, 0, 0);
    vecs[19] = mkv(1, 0, 0, 1, 32'hDEAD, 1,               0, 0, 32'h80, 32'h4040, 0, 1);
    vecs[20] = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h80, 32'h80, 0, 0, 0);
    vecs[21] = mkv(1, 0, 0, 1, 32'h8080, 0,               0, 0, 32'h80, 32'h8080, 1, 1);
    vecs[22] = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h81, 32'h81, 0, 0, 0);
    vecs[23] = mkv(1, 1, 32'h90, 1, 32'hDEAD, 1,          0, 0, 32'h90, 32'h8080, 0, 1);
    vecs[24] = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h90, 32'h90, 0, 0, 0);
    vecs[25] = mkv(1, 0, 0, 1, 32'h9090, 0,               0, 0, 32'h90, 32'h9090, 1, 1);
    vecs[26] = mkv(1, 1, 32'hFFFF_FFFF, 0, 0, 0,          1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    vecs[27] = mkv(1, 0, 0, 1, 32'hF00D, 1,               0, 0, 32'hFFFF_FFFF, 32'hF00D, 1, 1);
    vecs[28] = mkv(1, 0, 0, 0, 0, 1,                      1, 32'h0, 32'h0, 0, 0, 0);
    vecs[29] = mkv(0, 0, 0, 1, 32'h1111, 0,               0, 0, 32'h0, 32'h1111, 1, 1);
    vecs[30] = mkv(0, 0, 0, 0, 0, 1,                      0, 0, 32'h1, 0, 0, 0);
    vecs[31] = mkv(0, 0, 0, 1, 32'hBAD, 0,                0, 0, 32'h1, 0, 0, 0);
    vecs[32] = mkv(0, 1, 32'h200, 0, 0, 0,                0, 0, 32'h200, 0, 0, 0);
    vecs[33] = mkv(1, 0, 0, 0, 0, 0,                      1, 32'h200, 32'h200, 0, 0, 0);

    do_reset(1'b1);

    foreach (vecs[i]) begin
      @(negedge clk);
      run = vecs[i].run; redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
      mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata; ir_ready = vecs[i].ready;
      @(posedge clk);
      #1;
      check1($sformatf("v%0d_mem_rd", i), mem_rd, vecs[i].e_rd);
      check1($sformatf("v%0d_ir_valid", i), ir_valid, vecs[i].e_valid);
      check32($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      if (vecs[i].e_rd) check32($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      if (vecs[i].chk_ir) check32($sformatf("v%0d_ir", i), ir, vecs[i].e_ir);
    end

    // Asynchronous reset while a read is outstanding takes effect without a clock edge.
    @(negedge clk);
    drive_idle();
    run = 1'b1;
    #2 clr = 1'b0;
    #1;
    check1("async_clr_mem_rd", mem_rd, 1'b0);
    check32("async_clr_pc", pc, 32'h0);
    check1("async_clr_ir_valid", ir_valid, 1'b0);
    @(negedge clk);
    clr = 1'b1;

`ifdef FETCH_TIMEOUT_EN
    do_reset(1'b0);
    run = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      check1($sformatf("to_rd_c%0d", c), mem_rd, 1'b1);
      check1($sformatf("to_nofault_c%0d", c), fetch_fault, 1'b0);
    end
    @(posedge clk);
    #1;
    check1("to_fault", fetch_fault, 1'b1);
    check1("to_rd_drop", mem_rd, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check1("to_idle_held", mem_rd, 1'b0);
    check1("to_fault_sticky", fetch_fault, 1'b1);
`endif

    // Random traffic: every consumed instruction must be the next one in program order
    // (pc+1, or the most recent redirect target) and carry that address's memory word.
    do_reset(1'b0);
    exp_next   = 32'h0;
    prev_rd    = 1'b0;
    prev_addr  = 32'h0;
    acked_prev = 1'b0;
    wait_left  = 0;
    consumed   = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (acked_prev) check1("rd_after_ack", mem_rd, 1'b0);
      if (mem_rd && !prev_rd) begin
        check32("rise_addr", mem_addr, exp_next);
        wait_left = $urandom_range(0, 2);
      end else if (mem_rd && prev_rd) begin
        check32("addr_stable", mem_addr, prev_addr);
      end

      run      = ($urandom_range(0, 9) != 0);
      redirect = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFFE + 32'($urandom_range(0, 2));
      else                           redirect_pc = $urandom;
      ir_ready = ($urandom_range(0, 9) < 6);
      if (mem_rd) begin
        if (wait_left == 0) begin
          mem_ack = 1'b1; mem_rdata = memf(mem_addr);
        end else begin
          wait_left--;
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
      end else begin
        mem_ack = ($urandom_range(0, 19) == 0);
        mem_rdata = $urandom;
      end

      if (redirect) begin
        exp_next = redirect_pc;
      end else if (ir_valid && ir_ready) begin
        check32("consume_pc", pc, exp_next);
        check32("consume_ir", ir, memf(exp_next));
        consumed++;
        exp_next = exp_next + 32'd1;
      end

      acked_prev = mem_rd && mem_ack;
      prev_rd    = mem_rd;
      prev_addr  = mem_addr;
      @(negedge clk);
    end

    checks++;
    if (consumed < 50) begin
      errors++;
      $display("FAIL progress: got %0d consumed expected at least 50", consumed);
    end
`ifndef FETCH_TIMEOUT_EN
    check1("fault_tied_low", fetch_fault, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
